// File: rtl/scan_session_ctrl.sv
// Freeze / scan-and-DMA / resume session sequencer for a scanned design.
// Define SCAN_SESSION_CTRL_TIMEOUT_EN to build the WAIT-state watchdog.
`timescale 1ns/1ps
module scan_session_ctrl #(
    parameter int DRAIN_CYCLES   = 4,
    parameter int TIMEOUT_CYCLES = 1048576
) (
    input  logic        aclk,
    input  logic        areset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [15:0] req_length,
    input  logic [31:0] req_src,
    input  logic [31:0] req_dst,
    output logic        rsp_valid,
    output logic [1:0]  rsp_status,
    output logic        dut_clk_en,
    output logic        dma_start,
    output logic [31:0] dma_src,
    output logic [31:0] dma_dst,
    output logic [15:0] dma_length,
    input  logic        dma_done,
    output logic        scan_start,
    output logic [15:0] scan_length,
    input  logic        scan_done,
    output logic        busy
);
    typedef enum logic [2:0] {
        S_IDLE, S_FREEZE, S_LAUNCH, S_WAIT, S_RESUME, S_RESP
    } state_t;

    localparam logic [1:0] OP_HOLD    = 2'd1;
    localparam logic [1:0] OP_RESUME  = 2'd2;
    localparam logic [1:0] OP_BAD     = 2'd3;
    localparam logic [1:0] ST_OK      = 2'd0;
    localparam logic [1:0] ST_BADOP   = 2'd1;
    localparam logic [1:0] ST_BADLEN  = 2'd2;
    localparam logic [7:0] DRAIN_LAST = 8'(DRAIN_CYCLES - 1);

    state_t      state_q, state_d;
    logic        hold_q, hold_d;
    logic [7:0]  drain_cnt_q, drain_cnt_d;
    logic        dma_flag_q, dma_flag_d;
    logic        scan_flag_q, scan_flag_d;
    logic        clk_en_q, clk_en_d;
    logic        dma_start_q, dma_start_d;
    logic        scan_start_q, scan_start_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [1:0]  rsp_status_q, rsp_status_d;
    logic [31:0] src_q, src_d;
    logic [31:0] dst_q, dst_d;
    logic [15:0] len_q, len_d;
`ifdef SCAN_SESSION_CTRL_TIMEOUT_EN
    localparam logic [1:0]  ST_TIMEOUT = 2'd3;
    localparam logic [31:0] TMO_LAST   = 32'(TIMEOUT_CYCLES - 1);
    logic [31:0] tmo_cnt_q, tmo_cnt_d;
`endif

    always_comb begin
        state_d      = state_q;
        hold_d       = hold_q;
        drain_cnt_d  = drain_cnt_q;
        dma_flag_d   = dma_flag_q;
        scan_flag_d  = scan_flag_q;
        clk_en_d     = clk_en_q;
        rsp_status_d = rsp_status_q;
        src_d        = src_q;
        dst_d        = dst_q;
        len_d        = len_q;
`ifdef SCAN_SESSION_CTRL_TIMEOUT_EN
        tmo_cnt_d    = tmo_cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    src_d  = req_src;
                    dst_d  = req_dst;
                    len_d  = req_length;
                    hold_d = (req_op == OP_HOLD);
                    if (req_op == OP_BAD) begin
                        state_d      = S_RESP;
                        rsp_status_d = ST_BADOP;
                    end else if (req_op == OP_RESUME) begin
                        state_d = S_RESUME;
                    end else if (req_length == 16'd0) begin
                        state_d      = S_RESP;
                        rsp_status_d = ST_BADLEN;
                    end else begin
                        state_d     = S_FREEZE;
                        clk_en_d    = 1'b0;
                        drain_cnt_d = 8'd0;
                    end
                end
            end
            S_FREEZE: begin
                if (drain_cnt_q == DRAIN_LAST) begin
                    state_d = S_LAUNCH;
                end else begin
                    drain_cnt_d = drain_cnt_q + 8'd1;
                end
            end
            S_LAUNCH: begin
                dma_flag_d  = 1'b0;
                scan_flag_d = 1'b0;
`ifdef SCAN_SESSION_CTRL_TIMEOUT_EN
                tmo_cnt_d   = 32'd0;
`endif
                state_d     = S_WAIT;
            end
            S_WAIT: begin
                dma_flag_d  = dma_flag_q | dma_done;
                scan_flag_d = scan_flag_q | scan_done;
                // Completion wins over a watchdog expiry landing in the same cycle.
                if (dma_flag_d && scan_flag_d) begin
                    if (hold_q) begin
                        state_d      = S_RESP;
                        rsp_status_d = ST_OK;
                    end else begin
                        state_d = S_RESUME;
                    end
`ifdef SCAN_SESSION_CTRL_TIMEOUT_EN
                end else if (tmo_cnt_q == TMO_LAST) begin
                    state_d      = S_RESP;
                    rsp_status_d = ST_TIMEOUT;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 32'd1;
`endif
                end
            end
            S_RESUME: begin
                clk_en_d     = 1'b1;
                state_d      = S_RESP;
                rsp_status_d = ST_OK;
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        dma_start_d  = (state_d == S_LAUNCH);
        scan_start_d = (state_d == S_LAUNCH);
        rsp_valid_d  = (state_d == S_RESP);
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q      <= S_IDLE;
            hold_q       <= 1'b0;
            drain_cnt_q  <= 8'd0;
            dma_flag_q   <= 1'b0;
            scan_flag_q  <= 1'b0;
            clk_en_q     <= 1'b1;
            dma_start_q  <= 1'b0;
            scan_start_q <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_status_q <= 2'd0;
            src_q        <= 32'd0;
            dst_q        <= 32'd0;
            len_q        <= 16'd0;
`ifdef SCAN_SESSION_CTRL_TIMEOUT_EN
            tmo_cnt_q    <= 32'd0;
`endif
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            drain_cnt_q  <= drain_cnt_d;
            dma_flag_q   <= dma_flag_d;
            scan_flag_q  <= scan_flag_d;
            clk_en_q     <= clk_en_d;
            dma_start_q  <= dma_start_d;
            scan_start_q <= scan_start_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_status_q <= rsp_status_d;
            src_q        <= src_d;
            dst_q        <= dst_d;
            len_q        <= len_d;
`ifdef SCAN_SESSION_CTRL_TIMEOUT_EN
            tmo_cnt_q    <= tmo_cnt_d;
`endif
        end
    end

    // Ready is gated by the reset input so it reads 0 for the whole reset pulse.
    assign req_ready   = (state_q == S_IDLE) & ~areset;
    assign busy        = (state_q != S_IDLE);
    assign rsp_valid   = rsp_valid_q;
    assign rsp_status  = rsp_status_q;
    assign dut_clk_en  = clk_en_q;
    assign dma_start   = dma_start_q;
    assign scan_start  = scan_start_q;
    assign dma_src     = src_q;
    assign dma_dst     = dst_q;
    assign dma_length  = len_q;
    assign scan_length = len_q;

endmodule

// File: tb/tb_scan_session_ctrl.sv
// Self-checking bench for scan_session_ctrl: vector table, hand sequences, random sessions.
`timescale 1ns/1ps
module tb_scan_session_ctrl;
    localparam int DRAIN = 4;
    localparam int TMO   = 100;

    logic        aclk = 1'b0;
    logic        areset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_op = 2'd0;
    logic [15:0] req_length = 16'd0;
    logic [31:0] req_src = 32'd0;
    logic [31:0] req_dst = 32'd0;
    logic        rsp_valid;
    logic [1:0]  rsp_status;
    logic        dut_clk_en;
    logic        dma_start;
    logic [31:0] dma_src;
    logic [31:0] dma_dst;
    logic [15:0] dma_length;
    logic        dma_done = 1'b0;
    logic        scan_start;
    logic [15:0] scan_length;
    logic        scan_done = 1'b0;
    logic        busy;

    scan_session_ctrl #(.DRAIN_CYCLES(DRAIN), .TIMEOUT_CYCLES(TMO)) dut (
        .aclk(aclk), .areset(areset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_length(req_length), .req_src(req_src), .req_dst(req_dst),
        .rsp_valid(rsp_valid), .rsp_status(rsp_status), .dut_clk_en(dut_clk_en),
        .dma_start(dma_start), .dma_src(dma_src), .dma_dst(dma_dst),
        .dma_length(dma_length), .dma_done(dma_done),
        .scan_start(scan_start), .scan_length(scan_length), .scan_done(scan_done),
        .busy(busy)
    );

    always #5 aclk = ~aclk;

    int total = 0;
    int bad = 0;
    bit model_clk = 1'b1;

    typedef struct {
        logic [1:0]  op;
        logic [15:0] len;
        logic [31:0] src;
        logic [31:0] dst;
        int          sd;
        int          dd;
        logic [1:0]  st;
        bit          clk;
        bit          launch;
    } vec_t;

    vec_t tbl[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // sd/dd: cycle after the start pulse on which scan_done/dma_done fire; negative = never.
    task automatic run_session(input string tag, input logic [1:0] op, input logic [15:0] len,
                               input logic [31:0] src, input logic [31:0] dst,
                               input int sd, input int dd, input logic [1:0] exp_status,
                               input bit exp_clk, input bit exp_launch, input bit exp_rsp);
        int wait_cyc;
        int pulses;
        int frz;
        int k;
        int rsp_k;
        int budget;
        int exp_rsp_k;
        bit launched;
        bit got_rsp;
        if (sd < 0 || dd < 0) exp_rsp_k = TMO + 1;
        else exp_rsp_k = ((sd > dd) ? sd : dd) + ((op == 2'd0) ? 2 : 1);
        @(negedge aclk);
        req_op = op; req_length = len; req_src = src; req_dst = dst; req_valid = 1'b1;
        wait_cyc = 0;
        while (!req_ready && wait_cyc < 50) begin
            @(negedge aclk);
            wait_cyc++;
        end
        chk({tag, " req_ready"}, 32'(req_ready), 32'd1);
        @(negedge aclk);
        req_valid = 1'b0;
        pulses = 0; frz = 0; k = 0; rsp_k = -1; launched = 1'b0; got_rsp = 1'b0;
        budget = exp_rsp ? (exp_rsp_k + DRAIN + 20) : 300;
        for (int c = 0; c < budget; c++) begin
            if (launched) k++;
            if (rsp_valid) begin
                got_rsp = 1'b1;
                rsp_k = launched ? k : -1;
                break;
            end
            if (dma_start || scan_start) begin
                pulses++;
                chk({tag, " start pair"}, {30'd0, dma_start, scan_start}, 32'd3);
                chk({tag, " dma_src"}, dma_src, src);
                chk({tag, " dma_dst"}, dma_dst, dst);
                chk({tag, " dma_length"}, 32'(dma_length), 32'(len));
                chk({tag, " scan_length"}, 32'(scan_length), 32'(len));
                launched = 1'b1;
                k = 0;
            end else if (!launched && !dut_clk_en) begin
                frz++;
            end
            scan_done = launched && (k == sd);
            dma_done  = launched && (k == dd);
            @(negedge aclk);
        end
        scan_done = 1'b0;
        dma_done  = 1'b0;
        if (exp_rsp) begin
            chk({tag, " rsp seen"}, 32'(got_rsp), 32'd1);
            if (got_rsp) begin
                chk({tag, " rsp_status"}, 32'(rsp_status), 32'(exp_status));
                chk({tag, " dut_clk_en"}, 32'(dut_clk_en), 32'(exp_clk));
                chk({tag, " busy in rsp"}, 32'(busy), 32'd1);
                if (exp_launch) begin
                    chk({tag, " rsp latency"}, 32'(rsp_k), 32'(exp_rsp_k));
                    chk({tag, " dma_src held"}, dma_src, src);
                end
                @(negedge aclk);
                chk({tag, " rsp one cycle"}, 32'(rsp_valid), 32'd0);
                chk({tag, " idle busy"}, 32'(busy), 32'd0);
                chk({tag, " status held"}, 32'(rsp_status), 32'(exp_status));
            end
        end else begin
            chk({tag, " no rsp"}, 32'(got_rsp), 32'd0);
        end
        chk({tag, " start pulses"}, 32'(pulses), exp_launch ? 32'd1 : 32'd0);
        if (exp_launch) chk({tag, " freeze cycles"}, 32'(frz), 32'(DRAIN));
        $display("session %s op=%0d len=%0d status=%0d clk_en=%0d pulses=%0d", tag, op, len,
                 rsp_status, dut_clk_en, pulses);
    endtask

    task automatic pulse_reset(input string tag);
        @(negedge aclk);
        #2 areset = 1'b1;
        #1;
        chk({tag, " rst clk_en"}, 32'(dut_clk_en), 32'd1);
        chk({tag, " rst busy"}, 32'(busy), 32'd0);
        chk({tag, " rst req_ready"}, 32'(req_ready), 32'd0);
        chk({tag, " rst rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, " rst rsp_status"}, 32'(rsp_status), 32'd0);
        chk({tag, " rst starts"}, {30'd0, dma_start, scan_start}, 32'd0);
        chk({tag, " rst dma_src"}, dma_src, 32'd0);
        chk({tag, " rst lengths"}, {dma_length, scan_length}, 32'd0);
        @(negedge aclk);
        areset = 1'b0;
        #1;
        chk({tag, " ready after rst"}, 32'(req_ready), 32'd1);
        model_clk = 1'b1;
        $display("reset %s done", tag);
    endtask

    initial begin
        logic [1:0]  op;
        logic [15:0] len;
        logic [1:0]  st;
        bit          launch;
        int          seen;

        tbl[0] = '{2'd0, 16'd64,    32'h1000_0000, 32'h2000_0000, 10, 20, 2'd0, 1'b1, 1'b1};
        tbl[1] = '{2'd1, 16'd8,     32'h0000_1234, 32'h0000_5678,  5,  5, 2'd0, 1'b0, 1'b1};
        tbl[2] = '{2'd2, 16'd0,     32'h0,         32'h0,          1,  1, 2'd0, 1'b1, 1'b0};
        tbl[3] = '{2'd3, 16'd5,     32'hDEAD_BEEF, 32'h0,          1,  1, 2'd1, 1'b1, 1'b0};
        tbl[4] = '{2'd0, 16'd0,     32'h0,         32'h0,          1,  1, 2'd2, 1'b1, 1'b0};
        tbl[5] = '{2'd1, 16'hFFFF,  32'hFFFF_FFFF, 32'hA5A5_A5A5,  1,  1, 2'd0, 1'b0, 1'b1};
        tbl[6] = '{2'd3, 16'd9,     32'h0,         32'h0,          1,  1, 2'd1, 1'b0, 1'b0};
        tbl[7] = '{2'd0, 16'd0,     32'h0,         32'h0,          1,  1, 2'd2, 1'b0, 1'b0};
        tbl[8] = '{2'd0, 16'd1,     32'h0BAD_F00D, 32'h1,          7,  2, 2'd0, 1'b1, 1'b1};

        // Reset state, sampled while areset is still high.
        #12;
        chk("init clk_en", 32'(dut_clk_en), 32'd1);
        chk("init req_ready", 32'(req_ready), 32'd0);
        chk("init busy", 32'(busy), 32'd0);
        chk("init rsp_valid", 32'(rsp_valid), 32'd0);
        chk("init starts", {30'd0, dma_start, scan_start}, 32'd0);
        chk("init dma_dst", dma_dst, 32'd0);
        @(negedge aclk);
        areset = 1'b0;
        #1;
        chk("init ready after rst", 32'(req_ready), 32'd1);

        for (int i = 0; i < 9; i++) begin
            run_session($sformatf("vec%0d", i), tbl[i].op, tbl[i].len, tbl[i].src, tbl[i].dst,
                        tbl[i].sd, tbl[i].dd, tbl[i].st, tbl[i].clk, tbl[i].launch, 1'b1);
            model_clk = tbl[i].clk;
        end

`ifdef SCAN_SESSION_CTRL_TIMEOUT_EN
        run_session("timeout", 2'd0, 16'd32, 32'h100, 32'h200, 10, -1, 2'd3, 1'b0, 1'b1, 1'b1);
`else
        run_session("no_timeout", 2'd0, 16'd32, 32'h100, 32'h200, 10, -1, 2'd0, 1'b0, 1'b1, 1'b0);
`endif
        pulse_reset("after_wait");

        // Reset in the middle of WAIT: session abandoned, no response afterwards.
        @(negedge aclk);
        req_op = 2'd0; req_length = 16'd16; req_src = 32'h55; req_dst = 32'h66; req_valid = 1'b1;
        @(negedge aclk);
        req_valid = 1'b0;
        seen = 0;
        for (int c = 0; c < 20 && seen == 0; c++) begin
            if (dma_start) seen = 1;
            else @(negedge aclk);
        end
        chk("mid launch seen", 32'(seen), 32'd1);
        repeat (3) @(negedge aclk);
        chk("mid busy", 32'(busy), 32'd1);
        chk("mid clk_en low", 32'(dut_clk_en), 32'd0);
        pulse_reset("mid_wait");
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge aclk);
            if (rsp_valid) seen++;
        end
        chk("mid no rsp", 32'(seen), 32'd0);

        // Stray completions in IDLE must not shorten the next session.
        dma_done = 1'b1; scan_done = 1'b1;
        @(negedge aclk);
        dma_done = 1'b0; scan_done = 1'b0;
        run_session("stray", 2'd0, 16'd12, 32'h77, 32'h88, 3, 6, 2'd0, 1'b1, 1'b1, 1'b1);

        for (int i = 0; i < 40; i++) begin
            op  = 2'($urandom_range(0, 3));
            len = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom_range(1, 65535));
            launch = (op < 2'd2) && (len != 16'd0);
            if (op == 2'd3) st = 2'd1;
            else if (op < 2'd2 && len == 16'd0) st = 2'd2;
            else st = 2'd0;
            if (op == 2'd2 || (op == 2'd0 && launch)) model_clk = 1'b1;
            else if (op == 2'd1 && launch) model_clk = 1'b0;
            run_session($sformatf("rnd%0d", i), op, len, $urandom, $urandom,
                        int'($urandom_range(1, 12)), int'($urandom_range(1, 12)),
                        st, model_clk, launch, 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/scan_session_ctrl.md
SCAN_SESSION_CTRL -- requirements
Module: scan_session_ctrl

Interface
REQ-001 SHALL have parameter DRAIN_CYCLES, default 4, meaning cycles between DUT clock-enable deassert and transfer launch (legal range 1..255).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1048576, meaning watchdog limit in cycles for the WAIT state.
REQ-003 SHALL have port aclk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port areset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have ports req_valid in 1, req_ready out 1, req_op in 2, req_length in 16, req_src in 32, req_dst in 32: the session request channel.
REQ-006 SHALL have ports rsp_valid out 1 and rsp_status out 2: one-cycle completion pulse and status (0 OK, 1 BADOP, 2 BADLEN, 3 TIMEOUT).
REQ-007 SHALL have port dut_clk_en  output  1  functional clock enable of the scanned design.
REQ-008 SHALL have ports dma_start out 1, dma_src out 32, dma_dst out 32, dma_length out 16, dma_done in 1: DMA engine control.
REQ-009 SHALL have ports scan_start out 1, scan_length out 16, scan_done in 1: scan-shift engine control.
REQ-010 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-011 SHALL implement states IDLE, FREEZE, LAUNCH, WAIT, RESUME, RESP.
REQ-012 SHALL drive req_ready=1 only in IDLE; a request is accepted when req_valid & req_ready, and all request fields are registered at acceptance.
REQ-013 SHALL decode req_op: 0 SNAPSHOT (freeze, transfer, resume), 1 SNAPSHOT_HOLD (freeze, transfer, stay frozen), 2 RESUME (set dut_clk_en, no transfer), 3 reserved.
REQ-014 SHALL, on op 3, go IDLE->RESP with status BADOP, without touching dut_clk_en or start outputs.
REQ-015 SHALL, on op 0/1 with req_length=0, go IDLE->RESP with status BADLEN, without touching dut_clk_en or start outputs.
REQ-016 SHALL, on op 2, go IDLE->RESUME.
REQ-017 SHALL, on valid op 0/1, go IDLE->FREEZE, drive dut_clk_en=0 from the next cycle, and count DRAIN_CYCLES cycles before entering LAUNCH.
REQ-018 SHALL, in LAUNCH (exactly one cycle), pulse dma_start and scan_start high together for one cycle, then enter WAIT.
REQ-019 SHALL hold dma_src, dma_dst, dma_length and scan_length at the registered request values from acceptance until RESP is left; dma_length = scan_length = req_length.
REQ-020 SHALL, in WAIT, latch dma_done and scan_done into separate sticky flags; they may arrive in either order or in the same cycle; both set -> RESUME (op 0) or RESP (op 1).
REQ-021 SHALL ignore dma_done/scan_done outside WAIT; sticky flags clear on LAUNCH.
REQ-022 SHALL, in RESUME (one cycle), set dut_clk_en=1, then enter RESP.
REQ-023 SHALL, in RESP (one cycle), assert rsp_valid with rsp_status, then return to IDLE; rsp_status holds its value until the next RESP.
REQ-024 SHALL keep dut_clk_en unchanged by every op/path not listed above; dut_clk_en=0 persists across sessions after SNAPSHOT_HOLD.
REQ-025 SHALL issue back-to-back sessions with at least one IDLE cycle between RESP and the next acceptance.

Reset
REQ-026 SHALL, on areset, immediately enter IDLE, set dut_clk_en=1, req_ready=0 while areset high, dma_start=scan_start=rsp_valid=busy=0, rsp_status=0, all address/length outputs=0, sticky flags and counters=0.
REQ-027 SHALL, on areset mid-session, abandon the session with no rsp_valid; req_ready=1 on first cycle after release.

Configuration
REQ-028 SHALL compile the WAIT watchdog only when SCAN_SESSION_CTRL_TIMEOUT_EN is defined: counter cleared in LAUNCH, counts in WAIT; reaching TIMEOUT_CYCLES -> RESP with status TIMEOUT, dut_clk_en left 0.
REQ-029 SHALL, without SCAN_SESSION_CTRL_TIMEOUT_EN, wait in WAIT indefinitely and never emit status TIMEOUT.

Verification
REQ-030 SNAPSHOT, length=64, src=0x1000_0000, dst=0x2000_0000; scan_done +10, dma_done +20 -> dut_clk_en low 4 cycles before single-cycle start pulses, one RESUME, rsp_status=0, dut_clk_en=1.
REQ-031 SNAPSHOT_HOLD, length=8, dma_done and scan_done same cycle -> rsp_status=0, dut_clk_en stays 0; then op 2 -> rsp_status=0, dut_clk_en=1, no start pulses.
REQ-032 op 3 and op 0 with length=0 -> rsp_status=1 and 2 respectively, no start pulses, dut_clk_en unchanged at 1.
REQ-033 With macro defined, TIMEOUT_CYCLES=100, scan_done only -> rsp_status=3 exactly 100 cycles into WAIT, dut_clk_en=0; without the macro, no response.
REQ-034 areset asserted in WAIT -> dut_clk_en=1 asynchronously, no rsp_valid; stray dma_done in IDLE -> no effect on the next session.
